// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encoding.
package usr_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: selects the next value of the bit
// from itself, its right neighbour, its left neighbour or the load data.
module usr_bit_cell
  import usr_pkg::*;
(
  input  mode_t mode_i,
  input  logic  hold_i,
  input  logic  right_i,
  input  logic  left_i,
  input  logic  load_i,
  output logic  nxt_o
);

  // 4:1 next-value mux keyed by the operating mode
  always_comb begin
    nxt_o = hold_i;
    case (mode_i)
      MODE_HOLD: nxt_o = hold_i;
      MODE_SHR:  nxt_o = right_i;
      MODE_SHL:  nxt_o = left_i;
      MODE_LOAD: nxt_o = load_i;
      default:   nxt_o = hold_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// serial in and out at both ends, saturating shift counter and done pulse.
// State updates on the falling clk edge when NEG_EDGE = 1, rising otherwise.
// Optional feature: define ROTATE_EN to let rot = 1 turn shifts into rotates.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               NEG_EDGE  = 1'b1,
  parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d, q_nxt;
  logic             sout_q, sout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shr_tap, shl_tap;
  mode_t            mode_s;

  assign mode_s = mode_t'(mode);

`ifdef ROTATE_EN
  // With rot set, the bit leaving one end re-enters at the other end
  assign shr_tap = rot ? q_q[0]       : sin_r;
  assign shl_tap = rot ? q_q[WIDTH-1] : sin_l;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign shr_tap    = sin_r;
  assign shl_tap    = sin_l;
`endif

  // Per-bit next-value muxes; end bits take the serial/rotate taps
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic r_in, l_in;
    if (i == WIDTH - 1) begin : g_msb
      assign r_in = shr_tap;
    end else begin : g_mid_r
      assign r_in = q_q[i+1];
    end
    if (i == 0) begin : g_lsb
      assign l_in = shl_tap;
    end else begin : g_mid_l
      assign l_in = q_q[i-1];
    end
    usr_bit_cell u_cell (
      .mode_i  (mode_s),
      .hold_i  (q_q[i]),
      .right_i (r_in),
      .left_i  (l_in),
      .load_i  (d[i]),
      .nxt_o   (q_nxt[i])
    );
  end

  // Next-state for register, serial out, counter and done pulse
  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      case (mode_s)
        MODE_SHR, MODE_SHL: begin
          q_d    = q_nxt;
          sout_d = (mode_s == MODE_SHR) ? q_q[0] : q_q[WIDTH-1];
          if (cnt_q != CNT_MAX) begin
            cnt_d  = cnt_q + CNT_W'(1);
            done_d = (cnt_q == CNT_MAX - CNT_W'(1));
          end
        end
        MODE_LOAD: begin
          q_d    = q_nxt;
          sout_d = 1'b0;
          cnt_d  = '0;
        end
        default: ;
      endcase
    end
  end

  // State register on the selected clock edge, synchronous reset first
  if (NEG_EDGE) begin : g_neg
    always_ff @(negedge clk) begin
      if (rst) begin
        q_q    <= RESET_VAL;
        sout_q <= 1'b0;
        cnt_q  <= '0;
        done_q <= 1'b0;
      end else begin
        q_q    <= q_d;
        sout_q <= sout_d;
        cnt_q  <= cnt_d;
        done_q <= done_d;
      end
    end
  end else begin : g_pos
    always_ff @(posedge clk) begin
      if (rst) begin
        q_q    <= RESET_VAL;
        sout_q <= 1'b0;
        cnt_q  <= '0;
        done_q <= 1'b0;
      end else begin
        q_q    <= q_d;
        sout_q <= sout_d;
        cnt_q  <= cnt_d;
        done_q <= done_d;
      end
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: one falling-edge and one rising-edge
// instance share the same inputs and are checked against a behavioural model.
module tb_universal_shift_reg;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, sin_r, sin_l, rot;
  logic [1:0]   mode;
  logic [W-1:0] d;

  logic [W-1:0] q_n, q_p;
  logic         sout_n, sout_p, done_n, done_p;
  logic [3:0]   cnt_n, cnt_p;

  universal_shift_reg #(.WIDTH(W), .NEG_EDGE(1'b1)) dut_n (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_r(sin_r),
    .sin_l(sin_l), .rot(rot), .q(q_n), .sout(sout_n), .cnt(cnt_n), .done(done_n));

  universal_shift_reg #(.WIDTH(W), .NEG_EDGE(1'b0)) dut_p (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin_r(sin_r),
    .sin_l(sin_l), .rot(rot), .q(q_p), .sout(sout_p), .cnt(cnt_p), .done(done_p));

  int total = 0;
  int bad   = 0;

  // behavioural model: new and previous state
  int  m_q, m_sout, m_cnt, m_done;
  int  o_q, o_sout, o_cnt, o_done;
  bit  have_state = 1'b0;
`ifdef ROTATE_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int nb;
    int prev_cnt;
    o_q = m_q; o_sout = m_sout; o_cnt = m_cnt; o_done = m_done;
    m_done = 0;
    if (rst) begin
      m_q = 0; m_sout = 0; m_cnt = 0;
    end else if (en && mode == 2'b11) begin
      m_q = int'(d); m_sout = 0; m_cnt = 0;
    end else if (en && (mode == 2'b01 || mode == 2'b10)) begin
      prev_cnt = m_cnt;
      if (mode == 2'b01) begin
        m_sout = m_q % 2;
        nb     = (ROT_ON && rot) ? m_q % 2 : int'(sin_r);
        m_q    = (m_q / 2) + nb * (1 << (W - 1));
      end else begin
        m_sout = (m_q >> (W - 1)) % 2;
        nb     = (ROT_ON && rot) ? m_sout : int'(sin_l);
        m_q    = ((m_q * 2) % (1 << W)) + nb;
      end
      m_cnt  = (m_cnt + 1 > W) ? W : m_cnt + 1;
      m_done = (prev_cnt < W && m_cnt == W) ? 1 : 0;
    end
  endtask

  // Apply one input vector; entered and left at posedge+1.
  // After the falling edge only the NEG_EDGE=1 instance may have moved.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [W-1:0] dd, input logic sr, input logic sl,
                      input logic ro);
    rst = r; en = e; mode = m; d = dd; sin_r = sr; sin_l = sl; rot = ro;
    model_step();
    @(negedge clk); #1;
    cmp("neg_q", int'(q_n), m_q);
    cmp("neg_sout", int'(sout_n), m_sout);
    cmp("neg_cnt", int'(cnt_n), m_cnt);
    cmp("neg_done", int'(done_n), m_done);
    if (have_state) begin
      cmp("pos_q_held", int'(q_p), o_q);
      cmp("pos_cnt_held", int'(cnt_p), o_cnt);
      cmp("pos_done_held", int'(done_p), o_done);
    end
    @(posedge clk); #1;
    cmp("pos_q", int'(q_p), m_q);
    cmp("pos_sout", int'(sout_p), m_sout);
    cmp("pos_cnt", int'(cnt_p), m_cnt);
    cmp("pos_done", int'(done_p), m_done);
    cmp("neg_q_held", int'(q_n), m_q);
    have_state = 1'b1;
  endtask

  logic [W-1:0] q_tab [8]    = '{8'hD2, 8'hE9, 8'hF4, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF};
  logic         sout_tab [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b00; d = '0; sin_r = 1'b0; sin_l = 1'b0; rot = 1'b0;
    m_q = 0; m_sout = 0; m_cnt = 0; m_done = 0;
    @(posedge clk); #1;

    // reset wins over a load
    step(1'b1, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0);
    cmp("lit_rst_q", int'(q_n), 0);
    cmp("lit_rst_cnt", int'(cnt_p), 0);
    cmp("lit_rst_done", int'(done_n), 0);
    cmp("lit_rst_sout", int'(sout_p), 0);

    // load A5, shift right with sin_r = 1
    step(1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
      cmp("lit_shr_q", int'(q_p), int'(q_tab[i]));
      cmp("lit_shr_sout", int'(sout_n), int'(sout_tab[i]));
      cmp("lit_shr_done", int'(done_p), (i == 7) ? 1 : 0);
    end
    step(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);
    cmp("lit_sat_cnt", int'(cnt_p), 8);
    cmp("lit_sat_done", int'(done_n), 0);

    // load 81, shift left with sin_l = 0
    step(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0);
    cmp("lit_shl_q", int'(q_p), 8'h02);
    cmp("lit_shl_sout", int'(sout_p), 1);
    cmp("lit_shl_cnt", int'(cnt_n), 1);

    // en = 0 holds even with a shift mode
    step(1'b0, 1'b1, 2'b11, 8'h5A, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'b01, 8'h00, 1'b1, 1'b1, 1'b0);
      cmp("lit_en0_q", int'(q_p), 8'h5A);
      cmp("lit_en0_cnt", int'(cnt_n), 0);
    end

    // load mid-sequence restarts the count
    step(1'b0, 1'b1, 2'b11, 8'h11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 1'b0, 1'b0);
    cmp("lit_mid_cnt", int'(cnt_p), 5);
    step(1'b0, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0, 1'b0);
    cmp("lit_reload_cnt", int'(cnt_p), 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0);
      cmp("lit_reload_done", int'(done_n), (i == 7) ? 1 : 0);
    end

    // rotate select on a left shift
    step(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b1);
    cmp("lit_rot_q", int'(q_p), ROT_ON ? 8'h03 : 8'h02);
    cmp("lit_rot_sout", int'(sout_n), 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
